// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, combinational imem addressing,
// early j/jal resolution and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          EARLY_JUMP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic        is_jump;

    assign pc4         = pc_q + 32'd4;
    assign jump_target = {pc4[31:28], imem_instr[25:0], 2'b00};
    assign is_jump     = EARLY_JUMP &&
                         ((imem_instr[31:26] == 6'h02) || (imem_instr[31:26] == 6'h03));

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        // Redirect outranks stall: the squashed slot becomes a bubble.
        if (redirect_valid) begin
            pc_d    = redirect_target & ~32'd3;
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = is_jump ? jump_target : pc4;
            instr_d = imem_instr;
            pc4_d   = pc4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. It resolves unconditional jumps (`j`/`jal`) locally. It also obeys stall requests from the hazard unit and branch redirects from later stages. Downstream, the decode stage consumes `if_id_instr`, `if_id_pc4` and `if_id_valid`.

## Interface
- `RESET_PC`, default 32'h00000000: PC value loaded on reset.
- `EARLY_JUMP`, default 1: when 1, `j` (opcode 6'h02) and `jal` (opcode 6'h03) are redirected in fetch. When 0, they fall through as PC+4.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `stall` in 1: hazard-unit hold request. Freezes the PC and IF/ID.
- `redirect_valid` in 1: taken branch or jr resolved downstream. Squashes the current fetch.
- `redirect_target` in 32: new PC when `redirect_valid`=1. Bits [1:0] are ignored and forced to 00.
- `imem_addr` out 32: current PC, driven directly from the PC register (byte address).
- `imem_instr` in 32: instruction returned combinationally for `imem_addr`.
- `if_id_instr` out 32: IF/ID instruction.
- `if_id_pc4` out 32: IF/ID PC+4 of that instruction (link value for `jal`).
- `if_id_valid` out 1: 1 when IF/ID holds a real instruction, 0 for a bubble.

## Operation
- Memory read is combinational, so `imem_instr` is valid in the same cycle as `imem_addr`. The PC register is 32 bits. The memory decodes only [9:2], so PCs wrap modulo 1 KiB inside the memory. This is not an error.
- pc4 = pc + 32'd4, modulo 2^32. No overflow detection.
- jump_target = {pc4[31:28], imem_instr[25:0], 2'b00}.
- is_jump = EARLY_JUMP && imem_instr[31:26] is 6'h02 or 6'h03.
- Next-state priority at each rising edge, highest first:
  1. `redirect_valid`=1: pc <= {redirect_target[31:2],2'b00}. IF/ID <= bubble (instr 32'h0, pc4 32'h0, valid 0). This applies even if `stall`=1.
  2. `stall`=1: pc, if_id_instr, if_id_pc4 and if_id_valid all hold.
  3. `is_jump`: pc <= jump_target. IF/ID <= {imem_instr, pc4, 1}. The jump itself is passed on so decode can write the `jal` link. There is no delay slot and no bubble.
  4. Otherwise: pc <= pc4. IF/ID <= {imem_instr, pc4, 1}.
- A bubble is always the all-zero nop (32'h00000000) with valid=0.
- A fetched word of 32'h00000000 (explicit nop) is a real instruction and is passed with valid=1.
- There is no internal FSM beyond the PC and IF/ID registers. No multicycle fetch.

## Timing
- Reset (`rst_n`=0, asynchronous, takes effect immediately without waiting for `clk`):
  - pc = RESET_PC, so `imem_addr` = RESET_PC.
  - `if_id_instr` = 0, `if_id_pc4` = 0, `if_id_valid` = 0.
- Deassertion of `rst_n` has effect from the first rising edge where `rst_n` is sampled 1.
- Latency: one cycle from PC to IF/ID. The instruction at address A appears on `if_id_instr` one edge after `imem_addr`=A, when not stalled.
- Throughput: one instruction per cycle. A taken `j`/`jal` costs 0 bubbles. A downstream redirect costs 1 bubble in IF/ID for the squashed fetch. Squashing older instructions is the requester's job.
- Redirect and stall in the same cycle: the redirect wins, and the stall is dropped for that edge.
- Redirect and jump in the same cycle: the redirect wins.
- A redirect held high for several cycles reloads the same target and inserts a bubble every cycle.
- Reset asserted mid-stream: all state returns to reset values asynchronously. In-flight IF/ID contents are discarded.
- Combinational paths: `imem_instr` -> next pc and IF/ID D-inputs; `redirect_*`/`stall` -> next state. No input-to-output combinational path; all outputs are registered.

## Test plan
- Reset then free run with memory words 20080001, 20090002, 01095020, AC0A0000, 8C0B0000, 00000000 at 0x0..0x14:
  - `if_id_instr` shows those words on edges 1..6.
  - `if_id_pc4` reads 4, 8, C, 10, 14, 18.
  - `if_id_valid`=1 from edge 1 onward.
- Stall for 2 cycles while `imem_addr`=0x8: `imem_addr` stays 0x8 and IF/ID keeps {20090002, 8, 1} for both cycles, then resumes with 01095020.
- `j` 0x08000010 at 0x4, EARLY_JUMP=1: next `imem_addr`=0x40 with no bubble. IF/ID gets {08000010, 8, 1}, then the word at 0x40.
  - With EARLY_JUMP=0, the next address is 0x8.
- `redirect_valid`=1 with target 0x23 while `stall`=1 at pc=0xC: pc becomes 0x20 and IF/ID becomes {0, 0, 0}. On the next edge IF/ID receives the word at 0x20 with valid=1.
- Assert `rst_n`=0 between edges while at pc=0x14: `imem_addr`=RESET_PC and `if_id_valid`=0 immediately, without waiting for `clk`. Fetch restarts at 0x0 once `rst_n` is sampled 1.
- Wrap: redirect to 0xFFFFFFFC: `imem_addr`=FFFFFFFC, and the next pc is 0x00000000 with `if_id_pc4`=0.
